// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial-link virtual-channel scheduler.
// Typedefs are sized for the default configuration (4 VCs, 8 credits).
package serial_link_pkg;

    localparam int unsigned DefNumVc      = 4;
    localparam int unsigned DefMaxCredits = 8;

    typedef logic [$clog2(DefNumVc)-1:0]          vc_idx_t;
    typedef logic [$clog2(DefMaxCredits+1)-1:0]   credit_num_t;

    typedef struct packed {
        vc_idx_t     vc;
        credit_num_t num;
    } credit_ret_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Successor of a round-robin index, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/serial_link_rr_picker.sv
// Combinational round-robin picker: first eligible VC at or after the pointer,
// wrapping around. Produces a one-hot grant, its index and an any-valid flag.
module serial_link_rr_picker
    import serial_link_pkg::*;
#(
    parameter int unsigned NumVc = 4,
    localparam int unsigned VcIdxW = $clog2(NumVc)
) (
    input  logic [NumVc-1:0]  i_eligible,
    input  logic [VcIdxW-1:0] i_ptr,
    output logic [NumVc-1:0]  o_gnt,
    output logic [VcIdxW-1:0] o_idx,
    output logic              o_any
);

    always_comb begin
        int unsigned w_cand;
        logic        w_found;
        w_cand  = 0;
        w_found = 1'b0;
        o_gnt   = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int unsigned k = 0; k < NumVc; k++) begin
            w_cand = (32'(i_ptr) + k) % NumVc;
            if (!w_found && i_eligible[w_cand[VcIdxW-1:0]]) begin
                w_found                     = 1'b1;
                o_gnt[w_cand[VcIdxW-1:0]]   = 1'b1;
                o_idx                       = w_cand[VcIdxW-1:0];
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/serial_link_vc_scheduler.sv
// Credit-based round-robin scheduler merging NumVc payload streams onto one
// registered AXIS-style output toward the data-link layer.
module serial_link_vc_scheduler
    import serial_link_pkg::*;
#(
    parameter int unsigned NumVc       = 4,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned MaxCredits  = 8,
    localparam int unsigned CreditWidth = $clog2(MaxCredits+1),
    localparam int unsigned VcIdxW      = $clog2(NumVc)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic [NumVc-1:0]             in_valid_i,
    input  logic [NumVc*DataWidth-1:0]   in_data_i,
    output logic [NumVc-1:0]             in_ready_o,
    output logic                         out_valid_o,
    output logic [DataWidth-1:0]         out_data_o,
    output logic [VcIdxW-1:0]            out_vc_o,
    input  logic                         out_ready_i,
    input  logic                         credit_valid_i,
    input  logic [VcIdxW-1:0]            credit_vc_i,
    input  logic [CreditWidth-1:0]       credit_num_i,
    output logic [NumVc*CreditWidth-1:0] credits_o,
    output logic                         credit_err_o
);

    out_state_e             r_state;
    logic [DataWidth-1:0]   r_data;
    logic [VcIdxW-1:0]      r_vc;
    logic [VcIdxW-1:0]      r_ptr;
    logic [CreditWidth-1:0] r_credit [NumVc];
    logic                   r_err;

    logic [NumVc-1:0]       w_eligible;
    logic [NumVc-1:0]       w_gnt_oh;
    logic [VcIdxW-1:0]      w_idx;
    logic                   w_any;
    logic                   w_load;
    logic                   w_grant;
    logic                   w_ret_ok;
    logic                   w_ret_bad;
    logic [CreditWidth:0]   w_sum [NumVc];
    logic [CreditWidth-1:0] w_credit_nxt [NumVc];
    logic [NumVc-1:0]       w_ovf;

    always_comb begin
        w_eligible = '0;
        for (int unsigned i = 0; i < NumVc; i++) begin
            w_eligible[i] = in_valid_i[i] && (r_credit[i] != '0);
        end
    end

    serial_link_rr_picker #(.NumVc(NumVc)) u_picker (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_gnt      (w_gnt_oh),
        .o_idx      (w_idx),
        .o_any      (w_any)
    );

    // A stalled full output blocks new grants; a draining one can reload.
    assign w_load     = en_i && ((r_state == OUT_EMPTY) || out_ready_i);
    assign w_grant    = w_load && w_any && rst_ni;
    assign in_ready_o = w_grant ? w_gnt_oh : '0;

    assign w_ret_ok  = credit_valid_i && (32'(credit_vc_i) < NumVc);
    assign w_ret_bad = credit_valid_i && !(32'(credit_vc_i) < NumVc);

    // Return and grant combine at full precision before the ceiling check.
    always_comb begin
        w_ovf = '0;
        for (int unsigned i = 0; i < NumVc; i++) begin
            w_sum[i] = {1'b0, r_credit[i]}
                     + ((w_ret_ok && credit_vc_i == VcIdxW'(i)) ? {1'b0, credit_num_i} : '0)
                     - ((w_grant && w_idx == VcIdxW'(i)) ? (CreditWidth+1)'(1) : '0);
            if (w_sum[i] > (CreditWidth+1)'(MaxCredits)) begin
                w_ovf[i]        = 1'b1;
                w_credit_nxt[i] = CreditWidth'(MaxCredits);
            end else begin
                w_credit_nxt[i] = w_sum[i][CreditWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
            for (int unsigned i = 0; i < NumVc; i++) begin
                r_credit[i] <= CreditWidth'(MaxCredits);
            end
        end else begin
            r_err <= r_err || w_ret_bad || (|w_ovf);
            for (int unsigned i = 0; i < NumVc; i++) begin
                r_credit[i] <= w_credit_nxt[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= OUT_EMPTY;
            r_data  <= '0;
            r_vc    <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                OUT_EMPTY: begin
                    if (w_grant) begin
                        r_state <= OUT_FULL;
                        r_data  <= in_data_i[32'(w_idx)*DataWidth +: DataWidth];
                        r_vc    <= w_idx;
                        r_ptr   <= VcIdxW'(rr_next(32'(w_idx), NumVc));
                    end
                end
                OUT_FULL: begin
                    if (w_grant) begin
                        r_data  <= in_data_i[32'(w_idx)*DataWidth +: DataWidth];
                        r_vc    <= w_idx;
                        r_ptr   <= VcIdxW'(rr_next(32'(w_idx), NumVc));
                    end else if (out_ready_i) begin
                        r_state <= OUT_EMPTY;
                    end
                end
                default: r_state <= OUT_EMPTY;
            endcase
        end
    end

    assign out_valid_o  = (r_state == OUT_FULL);
    assign out_data_o   = r_data;
    assign out_vc_o     = r_vc;
    assign credit_err_o = r_err;

    always_comb begin
        credits_o = '0;
        for (int unsigned i = 0; i < NumVc; i++) begin
            credits_o[i*CreditWidth +: CreditWidth] = r_credit[i];
        end
    end

endmodule

// File: doc/serial_link_vc_scheduler.md
Name: serial_link_vc_scheduler

Overview:
Schedules NumVc independent network-layer payload streams (one per serial_link_axi_network instance or virtual channel) onto the single AXIS stream toward the data-link layer. Uses credit-based flow control: per-VC credit counters track the receiver buffer space, refilled by credit-return events from the remote side. Arbitration is round-robin among VCs that have both valid data and credits. Output is a registered stage with AXIS-stable semantics.

Parameters:
NumVc, 4, number of virtual channels; at least 2
DataWidth, 64, payload width per VC in bits
MaxCredits, 8, credits per VC after reset; also the saturation ceiling
CreditWidth, $clog2(MaxCredits+1), credit counter width (derived)
VcIdxW, $clog2(NumVc), VC index width (derived)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
en_i  in  1  scheduler enable; when low, no new grants are made
in_valid_i  in  NumVc  per-VC payload valid
in_data_i  in  NumVc*DataWidth  per-VC payload; VC i occupies bits [i*DataWidth +: DataWidth]
in_ready_o  out  NumVc  per-VC accept (one-hot or zero)
out_valid_o  out  1  scheduled payload valid
out_data_o  out  DataWidth  scheduled payload
out_vc_o  out  VcIdxW  VC index of out_data_o
out_ready_i  in  1  downstream accept
credit_valid_i  in  1  credit-return event
credit_vc_i  in  VcIdxW  VC receiving the returned credits
credit_num_i  in  CreditWidth  number of credits returned; 0 is legal (no-op)
credits_o  out  NumVc*CreditWidth  current credit count per VC
credit_err_o  out  1  sticky error: credit overflow or out-of-range credit_vc_i

Behaviour:
- Reset (rst_ni low at the clock edge):
  - out_valid_o=0; out_data_o=0; out_vc_o=0.
  - All credits=MaxCredits; round-robin pointer=0; credit_err_o=0.
  - in_ready_o=0 throughout the reset cycle.
  - A reset mid-transfer discards the output register contents.
- Eligibility: eligible[i] = in_valid_i[i] & (credit[i] != 0).
- Load condition: load = en_i & (~out_valid_o | out_ready_i). The output register is loadable when it is empty or being drained in the same cycle.
- Grant: when load is true and any VC is eligible, grant exactly one VC.
  - Choose the first eligible VC at or after the pointer, wrapping around.
  - in_ready_o[g]=1 for that cycle only; all other bits are 0.
  - in_ready_o is combinational from in_valid_i, credits, the pointer, en_i and out_ready_i.
- On grant to VC g, at the next clock edge:
  - out_valid_o=1, out_data_o=in_data_i[g], out_vc_o=g.
  - credit[g] decrements by 1.
  - Pointer becomes (g+1) mod NumVc, wrapping from NumVc-1 to 0.
- Latency: one cycle from the input handshake to out_valid_o.
  - Back-to-back throughput is 1 beat/cycle while out_ready_i=1 and credits are available.
- Drain without reload: if out_valid_o & out_ready_i and no grant occurs, out_valid_o goes to 0 at the next edge.
- Stability: while out_valid_o & ~out_ready_i, out_valid_o, out_data_o and out_vc_o hold, and no grant is made.
- en_i low:
  - No grants are made.
  - A pending output still completes its handshake; out_valid_o then falls.
  - Credits are still returned while en_i is low.
- Credit return: credit[credit_vc_i] += credit_num_i.
  - Same-cycle grant and return on the same VC: next = credit + credit_num_i − 1, evaluated at full precision.
  - If the result exceeds MaxCredits: clamp to MaxCredits and set credit_err_o.
  - credit_vc_i >= NumVc (possible only when NumVc is not a power of 2): ignore the return and set credit_err_o.
- credit_err_o is cleared only by reset.
- Credits are consumed only by the grant decrement; a returned credit is usable for arbitration the cycle after the return.
- A VC with credit 0 is skipped by arbitration; its in_valid_i may stay high indefinitely without blocking other VCs.
- Fairness: with N VCs continuously eligible, each VC is granted exactly once in every N consecutive grants.
- States: the output register has 2 states, Empty (out_valid_o=0) and Full (out_valid_o=1).
  - Empty→Full on a grant.
  - Full→Full on a grant with out_ready_i=1, or while stalled (out_ready_i=0).
  - Full→Empty on out_ready_i=1 with no grant.

Decomposition:
- serial_link_pkg holds the credit-return struct (vc, num) and a VC-index typedef parameterised by NumVc.
- The derived width constants are localparams of the module.
- Natural sub-module: a combinational round-robin priority picker, serial_link_rr_picker (inputs eligible vector and pointer; outputs one-hot grant and index). Alternatively reuse the common_cells rr_arb_tree with external-priority mode and no internal lock.
- Credit counters and the output register stay in the top module.

Test Plan:
- Reset release, NumVc=4, all in_valid_i=1, out_ready_i=1 → grants VC 0,1,2,3,0,… one per cycle; out_vc_o follows one cycle later; credits_o drop to 6 for each VC after 8 beats.
- VC1 only, MaxCredits=8, no credit return → exactly 8 beats accepted; then in_ready_o[1]=0 and out_valid_o=0. Return credit_num_i=3 on VC1 → 3 more beats accepted.
- out_ready_i=0 for 5 cycles with out_valid_o=1 → out_data_o/out_vc_o are stable, in_ready_o=0, and credits are unchanged.
- VC2 credit=0 with in_valid_i=1, VC0 and VC3 valid → only VC0 and VC3 are granted, alternating, with no stall cycles.
- VC0 at credit 7 receives a grant and a same-cycle return of 1 → credit stays at 7 and credit_err_o=0. A return of 2 at credit 8 → clamps to 8 and credit_err_o=1 (sticky until reset).
- Synchronous reset asserted while out_valid_o=1 and stalled → next edge gives out_valid_o=0, credits=MaxCredits, pointer=0; the first grant after reset goes to the lowest eligible VC.
